// File: rtl/tap_period_if.sv
// Tap-tempo bus: timepulse and debounced button in, averaged period and status out.
interface tap_period_if #(
  parameter int PER_W = 20
);
  logic             tp_i;
  logic             btn_i;
  logic [PER_W-1:0] period_o;
  logic             period_valid_o;
  logic             tapping_o;

  modport master (
    output tp_i, btn_i,
    input  period_o, period_valid_o, tapping_o
  );

  modport slave (
    input  tp_i, btn_i,
    output period_o, period_valid_o, tapping_o
  );
endinterface

// File: rtl/tap_period.sv
// Tap-tempo period meter: measures intervals between button taps in timepulse units
// and reports the average of the last four accepted intervals.
module tap_period #(
  parameter int PER_W       = 20,
  parameter int MIN_CNT     = 48_828,
  parameter int TIMEOUT_CNT = 390_625
) (
  input  logic         clk_i,
  input  logic         rst_i,
  tap_period_if.slave  tap
);

  localparam logic [PER_W-1:0] MIN_V = PER_W'(MIN_CNT);
  localparam logic [PER_W-1:0] TMO_V = PER_W'(TIMEOUT_CNT);

  typedef enum logic {S_IDLE, S_COUNT} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_btn_d;
  logic             w_rise;
  logic [PER_W-1:0] r_cnt, w_cnt_nxt;
  logic [PER_W-1:0] r_hist [4];
  logic             r_empty;
  logic             w_push, w_clr;
  logic             r_push_d;
  logic [PER_W+1:0] w_sum;
  logic [PER_W-1:0] r_period;
  logic             r_valid;
  logic             r_tapping;

  assign w_rise = tap.btn_i & ~r_btn_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_btn_d <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_btn_d <= tap.btn_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_clr       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_rise) begin
          w_state_nxt = S_COUNT;
          w_clr       = 1'b1;
        end
      end
      S_COUNT: begin
        // Timeout takes priority: a tap landing on it starts a fresh sequence.
        if (r_cnt == TMO_V) begin
          w_cnt_nxt = '0;
          w_clr     = 1'b1;
          if (!w_rise) w_state_nxt = S_IDLE;
        end else if (w_rise && (r_cnt >= MIN_V)) begin
          w_push    = 1'b1;
          w_cnt_nxt = '0;
        end else if (tap.tp_i) begin
          w_cnt_nxt = r_cnt + PER_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // First push into an empty history fills every slot so the average starts at that interval.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 4; i++) r_hist[i] <= '0;
      r_empty <= 1'b1;
    end else if (w_clr) begin
      r_empty <= 1'b1;
    end else if (w_push) begin
      r_empty <= 1'b0;
      if (r_empty) begin
        for (int unsigned i = 0; i < 4; i++) r_hist[i] <= r_cnt;
      end else begin
        for (int unsigned i = 3; i > 0; i--) r_hist[i] <= r_hist[i-1];
        r_hist[0] <= r_cnt;
      end
    end
  end

  always_comb begin
    w_sum = {2'b00, r_hist[0]} + {2'b00, r_hist[1]}
          + {2'b00, r_hist[2]} + {2'b00, r_hist[3]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_push_d  <= 1'b0;
      r_valid   <= 1'b0;
      r_period  <= '0;
      r_tapping <= 1'b0;
    end else begin
      r_push_d  <= w_push;
      r_valid   <= r_push_d;
      r_tapping <= (w_state_nxt == S_COUNT);
      if (r_push_d) r_period <= PER_W'(w_sum >> 2);
    end
  end

  assign tap.period_o       = r_period;
  assign tap.period_valid_o = r_valid;
  assign tap.tapping_o      = r_tapping;

endmodule

// File: tb/tb_tap_period.sv
// Scoreboard bench for tap_period: expected periods are queued per accepted tap,
// a monitor pops and compares on every period_valid_o strobe.
module tb_tap_period;
  localparam int PER_W = 20;

  logic clk = 1'b0;
  logic rst;

  tap_period_if #(.PER_W(PER_W)) tif ();

  tap_period #(
    .PER_W      (PER_W),
    .MIN_CNT    (4),
    .TIMEOUT_CNT(100)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .tap  (tif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [PER_W-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tif.period_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: got period %0d, expected no strobe", tif.period_o);
      end else begin
        check("period_strobe", 32'(tif.period_o), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the rise is seen on the following posedge.
  task automatic tap();
    tif.btn_i = 1'b1;
    @(negedge clk);
    tif.btn_i = 1'b0;
  endtask

  task automatic tap_exp(input logic [PER_W-1:0] v);
    exp_q.push_back(v);
    tap();
  endtask

  initial begin
    rst       = 1'b1;
    tif.tp_i  = 1'b1;
    tif.btn_i = 1'b0;
    #3;
    check("rst_period", 32'(tif.period_o), 0);
    check("rst_valid", 32'(tif.period_valid_o), 0);
    check("rst_tapping", 32'(tif.tapping_o), 0);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(2);
    check("idle_tapping", 32'(tif.tapping_o), 0);
    check("idle_period", 32'(tif.period_o), 0);

    // First tap starts, then intervals 20, 40, 40
    tap();
    check("start_tapping", 32'(tif.tapping_o), 1);
    wait_cyc(20); tap_exp(20);
    wait_cyc(40); tap_exp(25);
    wait_cyc(40); tap_exp(30);
    wait_cyc(5);
    check("avg_period_30", 32'(tif.period_o), 30);
    check("avg_tapping", 32'(tif.tapping_o), 1);

    // Tap exactly on timeout restarts the sequence with empty history
    wait_cyc(95); tap();
    check("tmo_rise_tapping", 32'(tif.tapping_o), 1);
    wait_cyc(8); tap_exp(8);
    wait_cyc(2);
    check("restart_period_8", 32'(tif.period_o), 8);

    // Timeout to idle, period held, new sequence reloads history
    wait_cyc(110);
    check("timeout_tapping", 32'(tif.tapping_o), 0);
    check("timeout_held", 32'(tif.period_o), 8);
    tap();
    wait_cyc(30); tap_exp(30);
    wait_cyc(30); tap_exp(30);
    wait_cyc(2);
    check("reload_period_30", 32'(tif.period_o), 30);

    // Glitch at counter 2 ignored, accepted tap at counter 20
    wait_cyc(110);
    tap();
    wait_cyc(2);  tap();
    wait_cyc(17); tap_exp(20);
    wait_cyc(2);
    check("glitch_period_20", 32'(tif.period_o), 20);

    // Button held high: one rise only, then timeout
    wait_cyc(110);
    tif.btn_i = 1'b1;
    wait_cyc(50);
    check("hold_tapping", 32'(tif.tapping_o), 1);
    wait_cyc(250);
    check("hold_timeout", 32'(tif.tapping_o), 0);
    check("hold_period", 32'(tif.period_o), 20);
    tif.btn_i = 1'b0;
    wait_cyc(2);

    // Asynchronous reset mid-sequence
    tap();
    wait_cyc(20); tap_exp(20);
    wait_cyc(48);
    #2 rst = 1'b1;
    #1;
    check("async_period", 32'(tif.period_o), 0);
    check("async_valid", 32'(tif.period_valid_o), 0);
    check("async_tapping", 32'(tif.tapping_o), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(30);
    check("post_rst_tapping", 32'(tif.tapping_o), 0);
    tap();
    wait_cyc(10); tap_exp(10);
    wait_cyc(3);
    check("post_rst_period", 32'(tif.period_o), 10);

    wait_cyc(5);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
